score_seg_driver: RTL

//   Sits between the BottleFlip game logic and the board's 4-digit 7-segment display (seg/an/dp pins).
//   - Accepts a binary score through a valid/ready handshake.
//   - Converts the score to BCD with a sequential shift-add-3 (double-dabble) engine.
//   - Time-multiplexes the four digits on the active-low seg/an/dp pins.

---
 rtl/score_seg_driver.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/score_seg_driver.sv
// -----------------------------------------------------------------------------
// score_seg_driver
//   Takes a binary score from the game logic through a valid/ready handshake.
//   A sequential double-dabble engine turns it into four BCD digits. The four
//   digits are then time-multiplexed onto an active-low 4-digit 7-segment
//   display.
//
//   Handshake: a score is accepted on a rising edge where score_valid and
//   score_ready are both high. score_ready is high only while the FSM is IDLE
//   and is low during reset. score_valid seen while score_ready is low is
//   ignored; there is no queueing.
//
//   Parameters
//     SCAN_DIV   clk cycles each digit stays lit (>= 2)
//     SCORE_W    width of score_in; the conversion takes exactly SCORE_W shifts
//     MAX_SCORE  inputs above this clamp to it; the decimal point of digit 0
//                is then lit
//
//   Ports
//     clk          system clock, rising edge
//     clr          synchronous active-high reset
//     score_in     binary score
//     score_valid  score_in valid this cycle
//     score_ready  block accepts a score (IDLE only)
//     seg          {g,f,e,d,c,b,a}, active low
//     an           digit enables, active low, an[0] = rightmost digit
//     dp           decimal point, active low (saturation marker on digit 0)
//
//   Build option
//     SEG_LEADING_ZERO_BLANK_EN: when defined, leading zero digits 3..1 are
//     blanked (seg = 7'h7F) while their anode is still driven. Digit 0 always
//     shows its numeral. When not defined, all four numerals are shown.
// -----------------------------------------------------------------------------
module score_seg_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SCORE_W-1:0] bin;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [4:0]         step;
    logic               sat_pending;
    logic [15:0]        disp;
    logic               sat_flag;
    logic [CNT_W-1:0]   scan_cnt;
    logic [1:0]         idx;
    logic [3:0]         nib;
    logic [6:0]         seg_nxt;
    logic               accept;

    assign accept = score_valid && score_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    if (step == 5'(SCORE_W - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // score_ready is registered. It stays low while clr is high, even though
    // the FSM is already parked in IDLE at that time.
    always_ff @(posedge clk) begin
        if (clr) score_ready <= 1'b0;
        else     score_ready <= (state_nxt == IDLE);
    end

    // ---------------- Double-dabble engine ----------------
    // Before each shift, add 3 to every nibble that is >= 5.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd_adj[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bin         <= '0;
            bcd         <= '0;
            step        <= '0;
            sat_pending <= 1'b0;
            disp        <= '0;
            sat_flag    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (score_in > SCORE_W'(MAX_SCORE)) begin
                            bin         <= SCORE_W'(MAX_SCORE);
                            sat_pending <= 1'b1;
                        end else begin
                            bin         <= score_in;
                            sat_pending <= 1'b0;
                        end
                        bcd  <= '0;
                        step <= '0;
                    end
                end
                CONV: begin
                    bcd  <= {bcd_adj[14:0], bin[SCORE_W-1]};
                    bin  <= bin << 1;
                    step <= step + 5'd1;
                end
                LOAD: begin
                    disp     <= bcd;
                    sat_flag <= sat_pending;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Digit scan ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // ---------------- Segment decode ----------------
    always_comb begin
        nib = disp[idx*4 +: 4];
        case (nib)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'h7F;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        if ((idx == 2'd3 && disp[15:12] == 4'd0) ||
            (idx == 2'd2 && disp[15:8]  == 8'd0) ||
            (idx == 2'd1 && disp[15:4]  == 12'd0))
            seg_nxt = 7'h7F;
`else
`endif
    end

    // ---------------- Output registers ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            seg <= 7'h7F;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= ~(4'b0001 << idx);
            dp  <= ~((idx == 2'd0) && sat_flag);
        end
    end

endmodule
